mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage between the execute pipeline register and data_memory.
//  Accepts one load/store request per handshake and drives the memory port
//  (16-bit words, word index = addr[8:1]). Adds byte loads (sign/zero extend)
//  and byte stores via 2-cycle read-modify-write. Returns load data to
//  writeback through a registered result port.
// PARAMETERS
//  DATA_W  16  data width; only 16 is supported (byte lanes fixed at 2)
//  ADDR_W  16  byte-address width
//  RD_W    3   destination register tag width
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       asynchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       unit can accept (high only in IDLE)
//  req_load       in   1       load request
//  req_store      in   1       store request
//  req_byte       in   1       1 = byte access, 0 = word access
//  req_signed     in   1       byte load: 1 = sign-extend, 0 = zero-extend
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   DATA_W  store data (byte store uses [7:0])
//  req_rd         in   RD_W    destination tag for loads
//  mem_addr       out  ADDR_W  to data_memory
//  mem_write_data out  DATA_W  to data_memory
//  mem_read       out  1       to data_memory
//  mem_write_en   out  1       to data_memory (written on next rising edge)
//  mem_read_data  in   DATA_W  from data_memory (combinational read)
//  wb_valid       out  1       one-cycle pulse: load result valid
//  wb_data        out  DATA_W  load result
//  wb_rd          out  RD_W    load destination tag
//  err            out  1       one-cycle pulse: request rejected
// BEHAVIOUR
//  - Reset: state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, err=0, internal
//    addr/merge registers=0. Memory outputs combinational, all 0 at reset.
//  - States: IDLE, RMW_WR. req_ready = (state==IDLE). Accept = valid&ready.
//  - Byte lanes little-endian: addr[0]=0 -> bits[7:0], addr[0]=1 -> [15:8].
//  - Reject (err=1 next cycle, no mem_read/mem_write_en, no wb_valid):
//    load&store both set; word access with addr[0]=1. load=store=0 with
//    valid: accepted as no-op, no err.
//  - Word load (IDLE): mem_addr=req_addr, mem_read=1; at edge wb_data<=
//    mem_read_data, wb_rd<=req_rd, wb_valid<=1. Latency 1, throughput 1/clk.
//  - Byte load: as word load; wb_data = selected byte extended per req_signed.
//  - Word store (IDLE): mem_addr=req_addr, mem_write_data=req_wdata,
//    mem_write_en=1 same cycle; memory updated at that edge. Stays IDLE.
//  - Byte store: IDLE cycle: mem_read=1, register addr and merged word
//    (req_wdata[7:0] into selected lane, other lane from mem_read_data);
//    -> RMW_WR. RMW_WR: mem_addr=latched addr, mem_write_data=merged,
//    mem_write_en=1, mem_read=0, req_ready=0; -> IDLE at next edge.
//  - wb_valid/err are pulses: cleared the cycle after set unless re-set.
//  - mem_write_data=0, mem_read=0, mem_write_en=0 when no access is driven.
//  - Address aliasing above word 255 is data_memory's concern; passed as-is.
//  - Reset asserted in RMW_WR: write_en drops immediately, memory word
//    unchanged, state IDLE, no err.
// TESTING
//  - Word store 0xBEEF @0x0010, then word load @0x0010 rd=3 -> wb_valid 1
//    cycle later, wb_data=0xBEEF, wb_rd=3.
//  - Word @0x0020=0x1234; byte store 0xAB @0x0021 -> ready low 1 cycle,
//    word load @0x0020 returns 0xAB34.
//  - Word @0x0030=0x80FF; byte load @0x0031 signed -> 0xFF80; unsigned
//    -> 0x0080; byte load @0x0030 signed -> 0xFFFF.
//  - Word load @0x0041 -> err pulse, no wb_valid, mem_read never 1;
//    load&store together -> err, memory unchanged.
//  - Assert rst during RMW_WR of byte store 0x55 @0x0050 (word=0x1111)
//    -> word stays 0x1111, outputs at reset values.
//  - Back-to-back 4 word loads with valid held -> 4 consecutive wb_valid
//    pulses with matching data/tags, req_ready never low.

Source files
------------

// File: rtl/mem_access_if.sv
// Load/store request, data_memory port and writeback result bundle.
//   req_*   : request handshake from the execute pipeline register
//   mem_*   : data_memory port (mem_read_data is a combinational read)
//   wb_*    : registered load result toward writeback
//   err     : one-cycle pulse when a request is rejected
// slave modport is the load/store unit side; master is the environment.
interface mem_access_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_W   = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_read_data;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              err;

  modport slave (
    input  req_valid, req_load, req_store, req_byte, req_signed,
           req_addr, req_wdata, req_rd, mem_read_data,
    output req_ready, mem_addr, mem_write_data, mem_read, mem_write_en,
           wb_valid, wb_data, wb_rd, err
  );

  modport master (
    output req_valid, req_load, req_store, req_byte, req_signed,
           req_addr, req_wdata, req_rd, mem_read_data,
    input  req_ready, mem_addr, mem_write_data, mem_read, mem_write_en,
           wb_valid, wb_data, wb_rd, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage between the execute pipeline register and data_memory.
// Word loads/stores complete in the accept cycle; byte loads select and
// extend one lane; byte stores do a 2-cycle read-modify-write (IDLE reads
// and merges, RMW_WR writes the merged word back).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_access_if.slave (request, memory port, writeback, err)
module mem_access_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_if.slave   bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EXT_W  = DATA_W - BYTE_W;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rmw_addr, rmw_addr_next;
  logic [DATA_W-1:0] rmw_data, rmw_data_next;
  logic              wb_valid_q, wb_valid_next;
  logic [DATA_W-1:0] wb_data_q, wb_data_next;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_next;
  logic              err_q, err_next;

  logic              accept;
  logic              bad_req;
  logic [BYTE_W-1:0] lane_byte;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  // Lane select, extension and merge for byte accesses (little-endian lanes).
  always_comb begin
    lane_byte = bus.req_addr[0] ? bus.mem_read_data[DATA_W-1:BYTE_W]
                                : bus.mem_read_data[BYTE_W-1:0];
    load_ext  = {{EXT_W{bus.req_signed & lane_byte[BYTE_W-1]}}, lane_byte};
    merged    = bus.req_addr[0]
              ? {bus.req_wdata[BYTE_W-1:0], bus.mem_read_data[BYTE_W-1:0]}
              : {bus.mem_read_data[DATA_W-1:BYTE_W], bus.req_wdata[BYTE_W-1:0]};
  end

  // Gating with rst keeps the memory port quiet while reset is held.
  assign accept  = bus.req_valid & (state == IDLE) & ~rst;
  assign bad_req = (bus.req_load & bus.req_store) |
                   ((bus.req_load | bus.req_store) & ~bus.req_byte & bus.req_addr[0]);

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rmw_addr   <= '0;
      rmw_data   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      rmw_addr   <= rmw_addr_next;
      rmw_data   <= rmw_data_next;
      wb_valid_q <= wb_valid_next;
      wb_data_q  <= wb_data_next;
      wb_rd_q    <= wb_rd_next;
      err_q      <= err_next;
    end
  end

  // Next-state, memory port drive and result capture.
  always_comb begin
    state_next         = state;
    rmw_addr_next      = rmw_addr;
    rmw_data_next      = rmw_data;
    wb_valid_next      = 1'b0;
    wb_data_next       = wb_data_q;
    wb_rd_next         = wb_rd_q;
    err_next           = 1'b0;
    bus.req_ready      = (state == IDLE);
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write_en   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            err_next = 1'b1;
          end else if (bus.req_load) begin
            bus.mem_addr  = bus.req_addr;
            bus.mem_read  = 1'b1;
            wb_valid_next = 1'b1;
            wb_data_next  = bus.req_byte ? load_ext : bus.mem_read_data;
            wb_rd_next    = bus.req_rd;
          end else if (bus.req_store) begin
            bus.mem_addr = bus.req_addr;
            if (bus.req_byte) begin
              // Read phase of RMW: latch address and the merged word.
              bus.mem_read  = 1'b1;
              rmw_addr_next = bus.req_addr;
              rmw_data_next = merged;
              state_next    = RMW_WR;
            end else begin
              bus.mem_write_data = bus.req_wdata;
              bus.mem_write_en   = 1'b1;
            end
          end
        end
      end
      RMW_WR: begin
        bus.req_ready      = 1'b0;
        bus.mem_addr       = rmw_addr;
        bus.mem_write_data = rmw_data;
        bus.mem_write_en   = ~rst;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-word behavioural data_memory.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [15:0] mem [256];

  mem_access_if #(.DATA_W(16), .ADDR_W(16), .RD_W(3)) bus ();

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .RD_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_memory: combinational read, write on rising edge.
  assign bus.mem_read_data = mem[bus.mem_addr[8:1]];
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr[8:1]] <= bus.mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_req();
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_wdata  = 16'h0000;
    bus.req_rd     = 3'd0;
  endtask

  task automatic set_req(input logic ld, input logic st, input logic bt, input logic sg,
                         input logic [15:0] a, input logic [15:0] wd, input logic [2:0] r);
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_byte   = bt;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, a, d, 3'd0);
    tick();
    idle_req();
  endtask

  // Single load, result sampled one cycle later.
  task automatic do_load(input string tag, input logic bt, input logic sg,
                         input logic [15:0] a, input logic [2:0] r,
                         input logic [15:0] exp_data);
    set_req(1'b1, 1'b0, bt, sg, a, 16'h0000, r);
    tick();
    idle_req();
    check({tag, "_valid"}, 32'(bus.wb_valid), 32'h1);
    check({tag, "_data"},  32'(bus.wb_data),  32'(exp_data));
    check({tag, "_rd"},    32'(bus.wb_rd),    32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_req();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    check("rst_wb_data",  32'(bus.wb_data),  32'h0);
    check("rst_wb_rd",    32'(bus.wb_rd),    32'h0);
    check("rst_err",      32'(bus.err),      32'h0);
    check("rst_we",       32'(bus.mem_write_en), 32'h0);
    check("rst_ready",    32'(bus.req_ready),    32'h1);
    rst = 1'b0;
    tick();

    // Word store then word load.
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd0);
    #1;
    check("wst_we",    32'(bus.mem_write_en),   32'h1);
    check("wst_addr",  32'(bus.mem_addr),       32'h0010);
    check("wst_wdata", 32'(bus.mem_write_data), 32'hBEEF);
    check("wst_rd",    32'(bus.mem_read),       32'h0);
    tick();
    idle_req();
    check("wst_mem", 32'(mem[8]), 32'hBEEF);
    check("wst_no_wb", 32'(bus.wb_valid), 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd3);
    #1;
    check("wld_read", 32'(bus.mem_read), 32'h1);
    tick();
    idle_req();
    check("wld_valid", 32'(bus.wb_valid), 32'h1);
    check("wld_data",  32'(bus.wb_data),  32'hBEEF);
    check("wld_rd",    32'(bus.wb_rd),    32'h3);
    tick();
    check("wld_pulse", 32'(bus.wb_valid), 32'h0);

    // Byte store read-modify-write into the high lane.
    wr_word(16'h0020, 16'h1234);
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB, 3'd0);
    #1;
    check("bst_read", 32'(bus.mem_read),     32'h1);
    check("bst_we0",  32'(bus.mem_write_en), 32'h0);
    tick();
    idle_req();
    check("bst_ready",  32'(bus.req_ready),      32'h0);
    check("bst_we1",    32'(bus.mem_write_en),   32'h1);
    check("bst_merged", 32'(bus.mem_write_data), 32'hAB34);
    check("bst_addr",   32'(bus.mem_addr),       32'h0021);
    tick();
    check("bst_ready2", 32'(bus.req_ready), 32'h1);
    check("bst_mem",    32'(mem[16]),       32'hAB34);
    do_load("bst_ld", 1'b0, 1'b0, 16'h0020, 3'd5, 16'hAB34);

    // Byte loads with sign/zero extension.
    wr_word(16'h0030, 16'h80FF);
    do_load("bld_hi_s", 1'b1, 1'b1, 16'h0031, 3'd1, 16'hFF80);
    do_load("bld_hi_u", 1'b1, 1'b0, 16'h0031, 3'd2, 16'h0080);
    do_load("bld_lo_s", 1'b1, 1'b1, 16'h0030, 3'd6, 16'hFFFF);

    // Rejected requests.
    wr_word(16'h0040, 16'h4444);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 3'd4);
    #1;
    check("mis_read", 32'(bus.mem_read), 32'h0);
    tick();
    idle_req();
    check("mis_err",   32'(bus.err),      32'h1);
    check("mis_no_wb", 32'(bus.wb_valid), 32'h0);
    tick();
    check("mis_pulse", 32'(bus.err), 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h9999, 3'd4);
    #1;
    check("ls_we", 32'(bus.mem_write_en), 32'h0);
    tick();
    idle_req();
    check("ls_err", 32'(bus.err),   32'h1);
    check("ls_mem", 32'(mem[32]),   32'h4444);

    // No-op request: accepted silently.
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 3'd0);
    tick();
    idle_req();
    check("nop_err", 32'(bus.err), 32'h0);

    // Reset during RMW_WR leaves memory untouched.
    wr_word(16'h0050, 16'h1111);
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0055, 3'd0);
    tick();
    idle_req();
    check("rr_we1",    32'(bus.mem_write_en),   32'h1);
    check("rr_merged", 32'(bus.mem_write_data), 32'h1155);
    rst = 1'b1;
    #1;
    check("rr_we0",    32'(bus.mem_write_en), 32'h0);
    check("rr_ready",  32'(bus.req_ready),    32'h1);
    tick();
    check("rr_mem",    32'(mem[40]),      32'h1111);
    check("rr_wbdata", 32'(bus.wb_data),  32'h0);
    check("rr_wbrd",   32'(bus.wb_rd),    32'h0);
    check("rr_err",    32'(bus.err),      32'h0);
    rst = 1'b0;
    tick();

    // Back-to-back word loads with valid held.
    for (int i = 0; i < 4; i++) wr_word(16'(16'h0060 + 2 * i), 16'(16'hA000 + i));
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0060 + 2 * i), 16'h0000, 3'(i + 1));
      #1;
      check("b2b_ready", 32'(bus.req_ready), 32'h1);
      tick();
      check("b2b_valid", 32'(bus.wb_valid), 32'h1);
      check("b2b_data",  32'(bus.wb_data),  32'(16'hA000 + i));
      check("b2b_rd",    32'(bus.wb_rd),    32'(i + 1));
    end
    idle_req();
    tick();
    check("b2b_end", 32'(bus.wb_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
